// File: rtl/dm_responder.sv
// Data-memory responder: the slave end of the core's load/store port.
// Accepts one word read or byte-enabled write per transaction and answers it after LATENCY wait cycles.
module dm_responder #(
  parameter int DEPTH_LOG2 = 10,  // log2 of word count; legal 1..29
  parameter int LATENCY    = 2    // extra wait cycles before the response; legal 0..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_write,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // The sender holds its payload until then; ready never depends on valid.
  localparam int        DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic      ZERO_LAT  = (LATENCY == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            wait_cnt;
  logic                  cap_write;
  logic [31:0]           cap_addr, cap_wdata;
  logic [3:0]            cap_be;
  logic [31:0]           rdata_q;
  logic                  err_q, write_q;
  logic                  accept, enter_resp, out_of_range;
  logic                  eff_write;
  logic [31:0]           eff_addr, eff_wdata;
  logic [3:0]            eff_be;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = ZERO_LAT ? ST_RESP : ST_WAIT;
      ST_WAIT: if (wait_cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    resp_write = write_q;
    dbg_state  = state;
  end

  // With zero latency the access commits on the accepting edge, so use the live request.
  assign accept     = (state == ST_IDLE) && req_valid;
  assign enter_resp = (accept && ZERO_LAT) || ((state == ST_WAIT) && (wait_cnt == 4'd0));
  assign eff_write  = (state == ST_IDLE) ? req_write : cap_write;
  assign eff_addr   = (state == ST_IDLE) ? req_addr  : cap_addr;
  assign eff_wdata  = (state == ST_IDLE) ? req_wdata : cap_wdata;
  assign eff_be     = (state == ST_IDLE) ? req_be    : cap_be;

  assign out_of_range = (eff_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
  assign word_idx     = eff_addr[DEPTH_LOG2+1:2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt  <= 4'd0;
      cap_write <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_be    <= 4'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
    end else begin
      if (accept) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_be    <= req_be;
        wait_cnt  <= WAIT_INIT;
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (enter_resp) begin
        write_q <= eff_write;
        err_q   <= out_of_range;
        rdata_q <= (!out_of_range && !eff_write) ? mem[word_idx] : 32'd0;
      end else if ((state == ST_RESP) && resp_ready) begin
        write_q <= 1'b0;
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  // Writes commit on RESP entry, so a following read always sees them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (enter_resp && eff_write && !out_of_range) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_be[b]) mem[word_idx][8*b +: 8] <= eff_wdata[8*b +: 8];
      end
    end
  end

endmodule
